hyperbus_responder: RTL and testbench
=====================================

Name: hyperbus_responder

Overview:
- Synthesizable HyperBus device-side responder, i.e. a HyperRAM-like slave, for on-chip loopback and FPGA/emulation of the SoC's HyperBus controller.
- Oversamples the host's CK, CS#, DQ and RWDS in the single system clock.
- Decodes the 48-bit command/address (CA) phase and serves linear read/write bursts from an internal word array.
- Holds one configuration register, CR0.

Parameters:
- Depth, 64: number of 16-bit words in the array; power of two, at least 2.
- SyncStages, 2: synchronizer flops applied identically to CK, CS#, DQ, RWDS and RESET#.
- LatCycles, 6: initial latency in CK cycles; always applied doubled (2x).
- Cr0Default, 16'h8F1F: CR0 value after reset.

Ports:
- clk_i  in  1  system clock; must be at least 8x the HyperBus CK frequency.
- rst_i  in  1  asynchronous, active-high reset.
- hyper_reset_ni  in  1  bus RESET#, active low.
- hyper_cs_ni  in  1  chip select, active low.
- hyper_ck_i  in  1  bus clock (CK) from the host.
- hyper_dq_i  in  8  DQ input.
- hyper_dq_o  out  8  DQ output.
- hyper_dq_oe_o  out  1  DQ output enable.
- hyper_rwds_i  in  1  RWDS input (write byte mask).
- hyper_rwds_o  out  1  RWDS output.
- hyper_rwds_oe_o  out  1  RWDS output enable.
- cr0_o  out  16  current CR0 value.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset (rst_i) values: all outputs 0 except cr0_o=Cr0Default; FSM in IDLE; counters cleared. Array contents are not reset.

Synchronization and edge detection:
- Every bus input passes through SyncStages flops, plus one history flop on CK.
- ck_edge = CK_sync XOR CK_prev. The edge is rising when CK_sync=1.
- DQ and RWDS are captured from the same synchronizer stage as CK_sync, so each captured byte is the value present at that edge.
- Outputs are registered. A new output byte appears SyncStages+1 clk_i cycles after the CK edge that requests it.

Bus reset: synchronized RESET# low behaves like CS# high (forced to IDLE) and also reloads CR0 with Cr0Default.

Abort: CS#_sync high in any state goes to IDLE on the next cycle and drops both output enables. A partially received write word is discarded.

FSM states and transitions:
- IDLE: on a CS#_sync falling edge, clear the edge counter, set rwds_oe=1 and rwds_o=1 (signals fixed 2x latency), go to CA.
- CA: shift in one byte per CK edge, MSB byte first. After 6 edges:
  - CA[47]=1 means read; CA[46]=1 means register space; CA[45] (burst type) is ignored, all bursts are linear.
  - word address = {CA[44:16],CA[2:0]} mod Depth.
  - Release RWDS (rwds_oe=0).
  - Register-space write goes to REGWR. All other transactions go to LAT with lat_cnt=4*LatCycles edges.
- LAT: decrement lat_cnt on each edge. At 0, go to RD (read) or WR (write).
- RD:
  - Drive dq_oe=1 and rwds_oe=1.
  - Each rising edge drives word[15:8] with rwds_o=1; each falling edge drives word[7:0] with rwds_o=0.
  - After the low byte, address increments and wraps modulo Depth.
  - A register-space read returns CR0 for every word.
- WR:
  - Rising edge captures the high byte and its mask (RWDS=1 means masked).
  - Falling edge captures the low byte and commits the word with per-byte enables.
  - Address increments and wraps modulo Depth.
- REGWR: two edges with no latency. The word is written to CR0, with RWDS ignored, and the FSM goes to WAIT_CS.
- WAIT_CS: ignore CK and wait for CS# high.

A burst continues until CS# rises; there is no burst length limit.

Decomposition:
- hyperbus_pkg (shared with the controller side) holds:
  - ca_t, a packed struct {rw, as, burst, row[28:0], rsvd[12:0], col[2:0]};
  - the state enum;
  - CA_BYTES=6.
- Sub-module hyperbus_resp_sync: synchronizer plus CK edge/polarity detector, emitting aligned {edge, rising, cs_n, dq, rwds}.

Test Plan:
1. Reset:
   - rst_i pulse → cr0_o=16'h8F1F, busy_o=0, dq_oe=0, rwds_oe=0.
   - During CA, rwds_oe=1 and rwds_o=1.
2. Write 4 words at word address 0x005, no mask: data 1111,2222,3333,4444. Then read 4 words from 0x005.
   - The read returns 1111,2222,3333,4444.
   - RWDS toggles 1/0 per byte.
   - The first read byte appears at edge 6+24.
3. Masked write:
   - Write word 0xABCD to address 0x005 with RWDS high on the low byte → the read-back is 0xAB11.
4. Wrap:
   - Write 3 words starting at Depth-1 (0x03F) → words land at 0x03F, 0x000, 0x001.
   - Read from 0x03F returns them in order.
5. Register space:
   - Register write CA with AS=1 and data 0x8F17 → cr0_o=16'h8F17 with no latency; further CK edges are ignored until CS# rises.
   - A register read returns 0x8F17.
6. Abort:
   - CS# rises after the high byte of a write → memory unchanged, busy_o=0 within SyncStages+2 cycles.
   - RESET# low → cr0_o=16'h8F1F.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared HyperBus definitions: command/address layout, FSM states and the
// sampled bus bundle used by the responder's synchronizer.
package hyperbus_pkg;

    localparam int CA_BYTES = 6;

    // 48-bit command/address word, MSB first on the wire.
    typedef struct packed {
        logic        rw;     // 1 = read
        logic        as;     // 1 = register space
        logic        burst;  // burst type (responder treats all bursts as linear)
        logic [28:0] row;    // upper word address
        logic [12:0] rsvd;
        logic [2:0]  col;    // lower word address
    } ca_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_RD,
        ST_WR,
        ST_REGWR,
        ST_WAIT_CS
    } state_e;

    // One sample of every bus input, carried through the synchronizer as a unit.
    typedef struct packed {
        logic       reset_n;
        logic       cs_n;
        logic       ck;
        logic       rwds;
        logic [7:0] dq;
    } bus_in_t;

    // Bus-idle sample: deselected, not in reset, CK low.
    localparam bus_in_t BUS_IDLE = '{reset_n: 1'b1, cs_n: 1'b1, ck: 1'b0, rwds: 1'b0, dq: 8'h00};

endpackage

// File: rtl/hyperbus_resp_sync.sv
// Synchronizes all HyperBus inputs into the system clock domain and detects
// CK edges. DQ/RWDS leave from the same stage as CK, so each sampled byte is
// aligned with the edge that qualifies it.
module hyperbus_resp_sync
    import hyperbus_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ck_i,
    input  logic       cs_ni,
    input  logic       reset_ni,
    input  logic       rwds_i,
    input  logic [7:0] dq_i,
    output logic       ck_edge_o,
    output logic       ck_rise_o,
    output logic       cs_n_o,
    output logic       reset_n_o,
    output logic       rwds_o,
    output logic [7:0] dq_o
);

    bus_in_t                  bus_in;
    bus_in_t [SyncStages-1:0] sync_d;
    bus_in_t [SyncStages-1:0] sync_q;
    logic                     ck_prev_d;
    logic                     ck_prev_q;

    assign bus_in = {reset_ni, cs_ni, ck_i, rwds_i, dq_i};

    // Next-state of the shift chain plus the CK history sample.
    always_comb begin
        // NOTE: every variable gets a default before any conditional/loop
        // assignment so no latch can be inferred.
        sync_d    = sync_q;
        sync_d[0] = bus_in;
        for (int i = 1; i < SyncStages; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        ck_prev_d = sync_q[SyncStages-1].ck;
    end

    // Synchronizer and history flops; reset to the bus-idle pattern.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            sync_q    <= {SyncStages{BUS_IDLE}};
            ck_prev_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            ck_prev_q <= ck_prev_d;
        end
    end

    assign ck_edge_o = sync_q[SyncStages-1].ck ^ ck_prev_q;
    assign ck_rise_o = sync_q[SyncStages-1].ck;
    assign cs_n_o    = sync_q[SyncStages-1].cs_n;
    assign reset_n_o = sync_q[SyncStages-1].reset_n;
    assign rwds_o    = sync_q[SyncStages-1].rwds;
    assign dq_o      = sync_q[SyncStages-1].dq;

endmodule

// File: rtl/hyperbus_responder.sv
// HyperBus device-side responder (HyperRAM-like): decodes the CA phase,
// serves linear read/write bursts from a word array and holds CR0.
// All bus timing is recovered by oversampling CK in clk_i.
module hyperbus_responder
    import hyperbus_pkg::*;
#(
    parameter int          Depth      = 64,
    parameter int          SyncStages = 2,
    parameter int          LatCycles  = 6,
    parameter logic [15:0] Cr0Default = 16'h8F1F
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hyper_reset_ni,
    input  logic        hyper_cs_ni,
    input  logic        hyper_ck_i,
    input  logic [7:0]  hyper_dq_i,
    output logic [7:0]  hyper_dq_o,
    output logic        hyper_dq_oe_o,
    input  logic        hyper_rwds_i,
    output logic        hyper_rwds_o,
    output logic        hyper_rwds_oe_o,
    output logic [15:0] cr0_o,
    output logic        busy_o
);

    localparam int AW   = $clog2(Depth);
    // Latency is always doubled, and each CK cycle has two edges.
    localparam int LatW = $clog2(4 * LatCycles + 1);
    localparam logic [LatW-1:0] LAT_LOAD = LatW'(4 * LatCycles);

    // Synchronized bus view
    logic       ck_edge;
    logic       ck_rise;
    logic       cs_n_s;
    logic       reset_n_s;
    logic       rwds_s;
    logic [7:0] dq_s;
    logic       cs_off;

    // FSM and datapath state
    state_e          state_q;
    logic [39:0]     ca_q;
    logic [2:0]      edge_cnt_q;
    logic [LatW-1:0] lat_cnt_q;
    logic [AW-1:0]   addr_q;
    logic            is_read_q;
    logic            is_reg_q;
    logic            cs_prev_q;
    logic [7:0]      wr_hi_q;
    logic            wr_hi_mask_q;
    logic [15:0]     cr0_q;
    logic [7:0]      dq_q;
    logic            dq_oe_q;
    logic            rwds_q;
    logic            rwds_oe_q;

    // Array write port, registered one cycle behind the committing edge
    logic [1:0]      mem_we_q;
    logic [AW-1:0]   mem_waddr_q;
    logic [15:0]     mem_wdata_q;
    logic [15:0]     mem [Depth];

    ca_t             ca_next;
    logic [31:0]     ca_word;
    logic [AW-1:0]   ca_addr;
    logic [15:0]     rd_word;
    logic            unused_ca;

    hyperbus_resp_sync #(
        .SyncStages (SyncStages)
    ) u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ck_i      (hyper_ck_i),
        .cs_ni     (hyper_cs_ni),
        .reset_ni  (hyper_reset_ni),
        .rwds_i    (hyper_rwds_i),
        .dq_i      (hyper_dq_i),
        .ck_edge_o (ck_edge),
        .ck_rise_o (ck_rise),
        .cs_n_o    (cs_n_s),
        .reset_n_o (reset_n_s),
        .rwds_o    (rwds_s),
        .dq_o      (dq_s)
    );

    // Bus reset looks exactly like a deselect to the FSM.
    assign cs_off    = cs_n_s | ~reset_n_s;

    // CA word as it stands once the current byte is shifted in.
    assign ca_next   = ca_t'({ca_q, dq_s});
    assign ca_word   = {ca_next.row, ca_next.col};
    assign ca_addr   = ca_word[AW-1:0];
    assign unused_ca = ^{ca_next.burst, ca_next.rsvd, ca_word[31:AW]};

    assign rd_word   = is_reg_q ? cr0_q : mem[addr_q];

    // Transaction FSM with registered bus outputs, CR0 and array write strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ca_q         <= '0;
            edge_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            addr_q       <= '0;
            is_read_q    <= 1'b0;
            is_reg_q     <= 1'b0;
            cs_prev_q    <= 1'b1;
            wr_hi_q      <= '0;
            wr_hi_mask_q <= 1'b0;
            cr0_q        <= Cr0Default;
            dq_q         <= '0;
            dq_oe_q      <= 1'b0;
            rwds_q       <= 1'b0;
            rwds_oe_q    <= 1'b0;
            mem_we_q     <= '0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
        end else begin
            mem_we_q  <= 2'b00;
            cs_prev_q <= cs_off;
            if (cs_off) begin
                // Deselect or bus reset: drop everything, discard partial words.
                state_q   <= ST_IDLE;
                dq_q      <= '0;
                dq_oe_q   <= 1'b0;
                rwds_q    <= 1'b0;
                rwds_oe_q <= 1'b0;
                if (!reset_n_s) begin
                    cr0_q <= Cr0Default;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cs_prev_q) begin
                            // RWDS high during CA advertises the fixed 2x latency.
                            edge_cnt_q <= '0;
                            rwds_oe_q  <= 1'b1;
                            rwds_q     <= 1'b1;
                            state_q    <= ST_CA;
                        end
                    end
                    ST_CA: begin
                        if (ck_edge) begin
                            ca_q       <= ca_next[39:0];
                            edge_cnt_q <= edge_cnt_q + 3'd1;
                            if (edge_cnt_q == 3'(CA_BYTES - 1)) begin
                                is_read_q <= ca_next.rw;
                                is_reg_q  <= ca_next.as;
                                addr_q    <= ca_addr;
                                rwds_oe_q <= 1'b0;
                                rwds_q    <= 1'b0;
                                if (!ca_next.rw && ca_next.as) begin
                                    edge_cnt_q <= '0;
                                    state_q    <= ST_REGWR;
                                end else begin
                                    lat_cnt_q <= LAT_LOAD;
                                    state_q   <= ST_LAT;
                                end
                            end
                        end
                    end
                    ST_LAT: begin
                        if (ck_edge) begin
                            lat_cnt_q <= lat_cnt_q - 1'b1;
                            if (lat_cnt_q == LatW'(1)) begin
                                if (is_read_q) begin
                                    dq_oe_q   <= 1'b1;
                                    rwds_oe_q <= 1'b1;
                                    rwds_q    <= 1'b0;
                                    state_q   <= ST_RD;
                                end else begin
                                    state_q <= ST_WR;
                                end
                            end
                        end
                    end
                    ST_RD: begin
                        if (ck_edge) begin
                            if (ck_rise) begin
                                dq_q   <= rd_word[15:8];
                                rwds_q <= 1'b1;
                            end else begin
                                dq_q   <= rd_word[7:0];
                                rwds_q <= 1'b0;
                                addr_q <= addr_q + 1'b1;
                            end
                        end
                    end
                    ST_WR: begin
                        if (ck_edge) begin
                            if (ck_rise) begin
                                wr_hi_q      <= dq_s;
                                wr_hi_mask_q <= rwds_s;
                            end else begin
                                // RWDS high masks the byte.
                                mem_we_q    <= {~wr_hi_mask_q, ~rwds_s};
                                mem_waddr_q <= addr_q;
                                mem_wdata_q <= {wr_hi_q, dq_s};
                                addr_q      <= addr_q + 1'b1;
                            end
                        end
                    end
                    ST_REGWR: begin
                        if (ck_edge) begin
                            if (edge_cnt_q == 3'd0) begin
                                wr_hi_q    <= dq_s;
                                edge_cnt_q <= 3'd1;
                            end else begin
                                cr0_q   <= {wr_hi_q, dq_s};
                                state_q <= ST_WAIT_CS;
                            end
                        end
                    end
                    ST_WAIT_CS: begin
                        state_q <= ST_WAIT_CS;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Word array with per-byte write enables.
    always_ff @(posedge clk_i) begin
        // NOTE: the array is deliberately not reset; it maps onto RAM, and a
        // reset would force it into discrete flops.
        if (mem_we_q[1]) begin
            mem[mem_waddr_q][15:8] <= mem_wdata_q[15:8];
        end
        if (mem_we_q[0]) begin
            mem[mem_waddr_q][7:0] <= mem_wdata_q[7:0];
        end
    end

    assign hyper_dq_o      = dq_q;
    assign hyper_dq_oe_o   = dq_oe_q;
    assign hyper_rwds_o    = rwds_q;
    assign hyper_rwds_oe_o = rwds_oe_q;
    assign cr0_o           = cr0_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hyperbus_responder.sv
// Self-checking bench for hyperbus_responder. The host side is driven at
// transaction level; a bench-side model (word array + CR0 + expected bus
// levels per phase) is compared against the DUT on every settled cycle.
module tb_hyperbus_responder;
    import hyperbus_pkg::*;

    localparam int          DEPTH     = 64;
    localparam int          LAT_EDGES = 24;   // 2 x 6 CK cycles, 2 edges each
    localparam logic [15:0] CR0_DEF   = 16'h8F1F;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        hyper_reset_ni;
    logic        hyper_cs_ni;
    logic        hyper_ck_i;
    logic [7:0]  hyper_dq_i;
    logic [7:0]  hyper_dq_o;
    logic        hyper_dq_oe_o;
    logic        hyper_rwds_i;
    logic        hyper_rwds_o;
    logic        hyper_rwds_oe_o;
    logic [15:0] cr0_o;
    logic        busy_o;

    hyperbus_responder #(
        .Depth      (DEPTH),
        .SyncStages (2),
        .LatCycles  (6),
        .Cr0Default (CR0_DEF)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .hyper_reset_ni  (hyper_reset_ni),
        .hyper_cs_ni     (hyper_cs_ni),
        .hyper_ck_i      (hyper_ck_i),
        .hyper_dq_i      (hyper_dq_i),
        .hyper_dq_o      (hyper_dq_o),
        .hyper_dq_oe_o   (hyper_dq_oe_o),
        .hyper_rwds_i    (hyper_rwds_i),
        .hyper_rwds_o    (hyper_rwds_o),
        .hyper_rwds_oe_o (hyper_rwds_oe_o),
        .cr0_o           (cr0_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [15:0] model_mem [DEPTH];
    logic [15:0] model_cr0;
    logic        chk_en = 1'b0;
    logic        exp_busy;
    logic        exp_dq_oe;
    logic        exp_rwds_oe;
    logic        exp_rwds;
    logic [7:0]  exp_dq;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model while the bus is settled.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cr0_o", cr0_o, model_cr0);
            check("busy_o", 16'(busy_o), 16'(exp_busy));
            check("dq_oe", 16'(hyper_dq_oe_o), 16'(exp_dq_oe));
            check("rwds_oe", 16'(hyper_rwds_oe_o), 16'(exp_rwds_oe));
            if (exp_rwds_oe) check("rwds_o", 16'(hyper_rwds_o), 16'(exp_rwds));
            if (exp_dq_oe) check("dq_o", 16'(hyper_dq_o), 16'(exp_dq));
        end
    end

    task automatic set_exp(input logic b, input logic dqoe, input logic rwoe,
                           input logic rw, input logic [7:0] d);
        exp_busy    = b;
        exp_dq_oe   = dqoe;
        exp_rwds_oe = rwoe;
        exp_rwds    = rw;
        exp_dq      = d;
    endtask

    // Outputs settle SyncStages+1 clocks after a bus change; checks are off meanwhile.
    task automatic settle();
        chk_en = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
    endtask

    // Enable checking for the rest of a 6-clock half period of CK.
    task automatic hold();
        chk_en = 1'b1;
        repeat (2) @(posedge clk_i);
    endtask

    task automatic ck_edge(input logic [7:0] d, input logic r);
        @(posedge clk_i);
        #2;
        hyper_dq_i   = d;
        hyper_rwds_i = r;
        hyper_ck_i   = ~hyper_ck_i;
        settle();
    endtask

    task automatic cs_set(input logic v);
        @(posedge clk_i);
        #2;
        hyper_cs_ni = v;
        settle();
    endtask

    task automatic begin_txn(input logic rw, input logic as, input int addr);
        ca_t         ca;
        logic [47:0] ca_bits;
        ca.rw    = rw;
        ca.as    = as;
        ca.burst = 1'b1;
        ca.row   = 29'(addr >> 3);
        ca.rsvd  = '0;
        ca.col   = 3'(addr);
        ca_bits  = ca;
        cs_set(1'b0);
        set_exp(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        hold();
        for (int i = 0; i < CA_BYTES; i++) begin
            ck_edge(ca_bits[47-8*i -: 8], 1'b0);
            if (i == CA_BYTES - 1) set_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            hold();
        end
    endtask

    task automatic latency(input logic rd);
        for (int i = 0; i < LAT_EDGES; i++) begin
            ck_edge(8'h00, 1'b0);
            // The last latency edge of a read is the bus turnaround: not compared.
            if (rd && i == LAT_EDGES - 1) repeat (2) @(posedge clk_i);
            else hold();
        end
    endtask

    task automatic write_word(inout int a, input logic [15:0] w, input logic [1:0] m);
        ck_edge(w[15:8], m[1]);
        hold();
        ck_edge(w[7:0], m[0]);
        if (!m[1]) model_mem[a][15:8] = w[15:8];
        if (!m[0]) model_mem[a][7:0]  = w[7:0];
        a = (a + 1) % DEPTH;
        hold();
    endtask

    task automatic read_word(inout int a, input logic reg_sp, output logic [15:0] got);
        logic [15:0] want;
        want = reg_sp ? model_cr0 : model_mem[a];
        ck_edge(8'h00, 1'b0);
        set_exp(1'b1, 1'b1, 1'b1, 1'b1, want[15:8]);
        got[15:8] = hyper_dq_o;
        hold();
        ck_edge(8'h00, 1'b0);
        set_exp(1'b1, 1'b1, 1'b1, 1'b0, want[7:0]);
        got[7:0] = hyper_dq_o;
        hold();
        a = (a + 1) % DEPTH;
    endtask

    task automatic end_txn();
        cs_set(1'b1);
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        hold();
        if (hyper_ck_i) begin
            ck_edge(8'h00, 1'b0);
            hold();
        end
    endtask

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int          a;
        logic [15:0] got;
        logic [15:0] pat [4];

        rst_i          = 1'b1;
        hyper_reset_ni = 1'b1;
        hyper_cs_ni    = 1'b1;
        hyper_ck_i     = 1'b0;
        hyper_dq_i     = 8'h00;
        hyper_rwds_i   = 1'b0;
        model_cr0      = CR0_DEF;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // 1. Reset values
        repeat (3) @(posedge clk_i);
        #2;
        check("rst_cr0", cr0_o, 16'h8F1F);
        check("rst_busy", 16'(busy_o), 16'h0000);
        check("rst_dq_oe", 16'(hyper_dq_oe_o), 16'h0000);
        check("rst_rwds_oe", 16'(hyper_rwds_oe_o), 16'h0000);
        rst_i = 1'b0;
        hold();
        hold();

        // 2. Four-word write at 0x005, then read back
        pat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        a = 5;
        begin_txn(1'b0, 1'b0, 5);
        latency(1'b0);
        for (int i = 0; i < 4; i++) write_word(a, pat[i], 2'b00);
        end_txn();

        a = 5;
        begin_txn(1'b1, 1'b0, 5);
        latency(1'b1);
        for (int i = 0; i < 4; i++) begin
            read_word(a, 1'b0, got);
            check("burst_read", got, pat[i]);
        end
        end_txn();

        // 3. Low byte masked
        a = 5;
        begin_txn(1'b0, 1'b0, 5);
        latency(1'b0);
        write_word(a, 16'hABCD, 2'b01);
        end_txn();
        a = 5;
        begin_txn(1'b1, 1'b0, 5);
        latency(1'b1);
        read_word(a, 1'b0, got);
        check("masked_read", got, 16'hAB11);
        end_txn();

        // 4. Address wrap from Depth-1
        pat = '{16'hA001, 16'hA002, 16'hA003, 16'h0000};
        a = DEPTH - 1;
        begin_txn(1'b0, 1'b0, DEPTH - 1);
        latency(1'b0);
        for (int i = 0; i < 3; i++) write_word(a, pat[i], 2'b00);
        end_txn();
        a = DEPTH - 1;
        begin_txn(1'b1, 1'b0, DEPTH - 1);
        latency(1'b1);
        for (int i = 0; i < 3; i++) begin
            read_word(a, 1'b0, got);
            check("wrap_read", got, pat[i]);
        end
        end_txn();
        a = 0;
        begin_txn(1'b1, 1'b0, 0);
        latency(1'b1);
        read_word(a, 1'b0, got);
        check("wrap_addr0", got, 16'hA002);
        end_txn();

        // 5. Register write (no latency, RWDS ignored), extra edges ignored, read back
        begin_txn(1'b0, 1'b1, 0);
        ck_edge(8'h8F, 1'b1);
        hold();
        ck_edge(8'h17, 1'b1);
        model_cr0 = 16'h8F17;
        hold();
        check("regwr_cr0", cr0_o, 16'h8F17);
        ck_edge(8'hFF, 1'b0);
        hold();
        ck_edge(8'hFF, 1'b0);
        hold();
        end_txn();
        check("regwr_ignored", cr0_o, 16'h8F17);

        a = 0;
        begin_txn(1'b1, 1'b1, 0);
        latency(1'b1);
        for (int i = 0; i < 2; i++) begin
            read_word(a, 1'b1, got);
            check("reg_read", got, 16'h8F17);
        end
        end_txn();

        // 6a. Abort after the high byte of a write
        a = 5;
        begin_txn(1'b0, 1'b0, 5);
        latency(1'b0);
        ck_edge(8'h55, 1'b0);
        hold();
        end_txn();
        a = 5;
        begin_txn(1'b1, 1'b0, 5);
        latency(1'b1);
        read_word(a, 1'b0, got);
        check("abort_mem", got, 16'hAB11);
        end_txn();

        // 6b. Bus RESET# during CA
        cs_set(1'b0);
        set_exp(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        hold();
        ck_edge(8'hA0, 1'b0);
        hold();
        ck_edge(8'h00, 1'b0);
        hold();
        @(posedge clk_i);
        #2;
        hyper_reset_ni = 1'b0;
        settle();
        model_cr0 = CR0_DEF;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        hold();
        check("busrst_cr0", cr0_o, 16'h8F1F);
        cs_set(1'b1);
        hold();
        @(posedge clk_i);
        #2;
        hyper_reset_ni = 1'b1;
        settle();
        hold();
        hold();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
